// File: rtl/demux_pkg.sv
// Shared types and constants for the tdm_demux8 receive path.
package demux_pkg;

    localparam int SLOT_W_DEF = 3;
    localparam int LANES      = 8;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder; the receive-side mirror of the M8 selector.
module dec3to8
    import demux_pkg::*;
(
    input  logic [2:0]       sel,
    input  logic             en,
    output logic [LANES-1:0] onehot
);

    // NOTE: default assignment first so every path drives onehot and no latch is inferred.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// Time-division demultiplexer: serial slots -> registered 8-bit word with valid strobe.
// Define DEMUX_SYNC_CHECK_EN to require sync on every slot 0; otherwise runs in flywheel mode.
module tdm_demux8
    import demux_pkg::*;
#(
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 din,
    input  logic                 sync,
    output logic [2**SLOT_W-1:0] y,
    output logic                 valid,
    output logic [SLOT_W-1:0]    slot,
    output logic                 locked,
    output logic                 err
);

    localparam int NLANES = 2**SLOT_W;

`ifdef DEMUX_SYNC_CHECK_EN
    localparam bit SYNC_CHECK = 1'b1;
`else
    localparam bit SYNC_CHECK = 1'b0;
`endif

    state_t              state;
    logic [NLANES-1:0]   shadow;
    logic [NLANES-1:0]   we;
    logic [SLOT_W-1:0]   write_sel;
    logic                early_sync;
    logic                sync_miss;
    logic                write_ok;
    logic                frame_done;

    // Any accepted sync restarts the frame, so the write lands in lane 0 regardless of slot.
    always_comb begin
        early_sync = (state == RECV) && sync && (slot != '0);
        sync_miss  = SYNC_CHECK && (state == RECV) && !sync && (slot == '0);
        write_ok   = (state == HUNT) ? sync : !sync_miss;
        write_sel  = sync ? '0 : slot;
        frame_done = (state == RECV) && !sync && (slot == '1);
    end

    dec3to8 u_dec (
        .sel    (write_sel),
        .en     (en && write_ok),
        .onehot (we)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HUNT;
            slot   <= '0;
            shadow <= '0;
            y      <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            locked <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;

            for (int k = 0; k < NLANES; k++) begin
                if (we[k]) begin
                    shadow[k] <= din;
                end
            end

            if (en) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            state  <= RECV;
                            slot   <= SLOT_W'(1);
                            locked <= 1'b1;
                        end
                    end
                    RECV: begin
                        if (early_sync) begin
                            err  <= 1'b1;
                            slot <= SLOT_W'(1);
                        end else if (sync_miss) begin
                            err    <= 1'b1;
                            state  <= HUNT;
                            slot   <= '0;
                            locked <= 1'b0;
                        end else begin
                            slot <= slot + SLOT_W'(1);
                            if (frame_done) begin
                                y     <= {din, shadow[NLANES-2:0]};
                                valid <= 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
